// File: rtl/pipe_scheduler.sv
// pipe_scheduler: game-phase FSM plus the scrolling pipe datapath.
// Owns idle/run/halt, scrolls N_PIPE pipe gaps at a divided rate, respawns
// expired pipes with LFSR-derived gap bounds, detects bird/pipe collision
// and counts passed pipes.
module pipe_scheduler #(
    parameter int         N_PIPE    = 3,
    parameter int         SPACING   = 50,
    parameter int         STEP_DIV  = 3,
    parameter int         GAP       = 10,
    parameter int         HIT_W     = 2,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  freeze,
    input  logic [7:0]            n_row,
    input  logic [7:0]            bird_alt,
    output logic [1:0]            state,
    output logic [24*N_PIPE-1:0]  pipes,
    output logic [15:0]           score,
    output logic                  score_inc,
    output logic                  collide
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int              DIV_W       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(STEP_DIV - 1);
    localparam logic [7:0]      RESPAWN_POS = 8'(N_PIPE * SPACING);
    localparam logic [7:0]      INIT_MIN    = 8'd15;
    localparam logic [7:0]      INIT_MAX    = 8'(15 + GAP);
    localparam logic [7:0]      GAP_8       = 8'(GAP);
    localparam logic [7:0]      HIT_8       = 8'(HIT_W);

    // Fibonacci LFSR step for x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Starting column of slot i after reset or restart.
    function automatic logic [7:0] init_pos(input int i);
        return 8'(SPACING * (i + 1));
    endfunction

    state_t           state_r, state_nxt_s;
    logic [DIV_W-1:0] div_r, div_nxt_s;
    logic [7:0]       lfsr_r;
    logic [7:0]       pos_r   [N_PIPE];
    logic [7:0]       min_r   [N_PIPE];
    logic [7:0]       max_r   [N_PIPE];
    logic [7:0]       pos_nxt_s [N_PIPE];
    logic [7:0]       min_nxt_s [N_PIPE];
    logic [7:0]       max_nxt_s [N_PIPE];
    logic [15:0]      score_r, score_nxt_s;
    logic             score_inc_r, score_inc_nxt_s;
    logic             collide_r, collide_nxt_s;

    logic [7:0]       cand_s;
    logic [8:0]       cand_sum_s;
    logic [7:0]       resp_min_s;
    logic [7:0]       resp_max_s;
    logic             hit_s;
    logic [15:0]      pass_cnt_s;
    logic [16:0]      score_sum_s;

    // Respawn gap bounds from the current LFSR value; too-tall gaps fall back to the floor.
    always_comb begin
        cand_s     = 8'd2 + {3'b000, lfsr_r[4:0]};
        cand_sum_s = {1'b0, cand_s} + {1'b0, GAP_8} + 9'd2;
        if (cand_sum_s > {1'b0, n_row}) begin
            resp_min_s = 8'd2;
        end else begin
            resp_min_s = cand_s;
        end
        resp_max_s = resp_min_s + GAP_8;
    end

    // Collision: ground contact, or bird outside the gap of any pipe at the bird column.
    always_comb begin
        hit_s = (bird_alt == 8'd0);
        for (int i = 0; i < N_PIPE; i++) begin
            hit_s = hit_s | ((pos_r[i] <= HIT_8) &&
                             ((bird_alt <= min_r[i]) || (bird_alt >= max_r[i])));
        end
    end

    // Next-state and datapath update for the phase FSM.
    always_comb begin
        state_nxt_s     = state_r;
        div_nxt_s       = div_r;
        pos_nxt_s       = pos_r;
        min_nxt_s       = min_r;
        max_nxt_s       = max_r;
        score_nxt_s     = score_r;
        score_inc_nxt_s = 1'b0;
        collide_nxt_s   = collide_r;
        pass_cnt_s      = 16'd0;
        score_sum_s     = 17'd0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_RUN;
                    div_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (freeze) begin
                    state_nxt_s = ST_RUN;
                end else if (hit_s) begin
                    state_nxt_s   = ST_HALT;
                    collide_nxt_s = 1'b1;
                end else if (div_r == DIV_LAST) begin
                    div_nxt_s = '0;
                    for (int i = 0; i < N_PIPE; i++) begin
                        if (pos_r[i] == 8'd0) begin
                            pos_nxt_s[i] = RESPAWN_POS;
                            min_nxt_s[i] = resp_min_s;
                            max_nxt_s[i] = resp_max_s;
                        end else begin
                            pos_nxt_s[i] = pos_r[i] - 8'd1;
                            if (pos_r[i] == 8'd1) begin
                                pass_cnt_s = pass_cnt_s + 16'd1;
                            end else begin
                                pass_cnt_s = pass_cnt_s;
                            end
                        end
                    end
                    score_sum_s     = {1'b0, score_r} + {1'b0, pass_cnt_s};
                    score_nxt_s     = score_sum_s[16] ? 16'hFFFF : score_sum_s[15:0];
                    score_inc_nxt_s = (pass_cnt_s != 16'd0);
                end else begin
                    div_nxt_s = div_r + DIV_W'(1);
                end
            end
            ST_HALT: begin
                collide_nxt_s = 1'b1;
                if (start) begin
                    state_nxt_s   = ST_IDLE;
                    div_nxt_s     = '0;
                    score_nxt_s   = 16'd0;
                    collide_nxt_s = 1'b0;
                    for (int i = 0; i < N_PIPE; i++) begin
                        pos_nxt_s[i] = init_pos(i);
                        min_nxt_s[i] = INIT_MIN;
                        max_nxt_s[i] = INIT_MAX;
                    end
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and LFSR registers; the LFSR free-runs in every phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            div_r       <= '0;
            lfsr_r      <= LFSR_SEED;
            score_r     <= 16'd0;
            score_inc_r <= 1'b0;
            collide_r   <= 1'b0;
            for (int i = 0; i < N_PIPE; i++) begin
                pos_r[i] <= init_pos(i);
                min_r[i] <= INIT_MIN;
                max_r[i] <= INIT_MAX;
            end
        end else begin
            state_r     <= state_nxt_s;
            div_r       <= div_nxt_s;
            lfsr_r      <= lfsr_next(lfsr_r);
            score_r     <= score_nxt_s;
            score_inc_r <= score_inc_nxt_s;
            collide_r   <= collide_nxt_s;
            pos_r       <= pos_nxt_s;
            min_r       <= min_nxt_s;
            max_r       <= max_nxt_s;
        end
    end

    // Pack the slot registers onto the view bus.
    always_comb begin
        pipes = '0;
        for (int i = 0; i < N_PIPE; i++) begin
            pipes[24*i +: 24] = {pos_r[i], max_r[i], min_r[i]};
        end
    end

    assign state     = state_r;
    assign score     = score_r;
    assign score_inc = score_inc_r;
    assign collide   = collide_r;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed testbench for pipe_scheduler with hand-computed expectations.
module tb_pipe_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        freeze = 1'b0;
    logic [7:0]  n_row = 8'd40;
    logic [7:0]  bird_alt = 8'd20;
    logic [1:0]  state;
    logic [71:0] pipes;
    logic [15:0] score;
    logic        score_inc;
    logic        collide;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, seed A5, steps every clock.
    logic [7:0] m_lfsr;

    pipe_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .freeze   (freeze),
        .n_row    (n_row),
        .bird_alt (bird_alt),
        .state    (state),
        .pipes    (pipes),
        .score    (score),
        .score_inc(score_inc),
        .collide  (collide)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [7:0] f_pos(int i); return pipes[24*i+16 +: 8]; endfunction
    function automatic logic [7:0] f_max(int i); return pipes[24*i+8 +: 8];  endfunction
    function automatic logic [7:0] f_min(int i); return pipes[24*i +: 8];    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [23:0] exp_slot;
        #2 rst_n = 1'b0;
        n_row = 8'd40; bird_alt = 8'd20; start = 1'b0; freeze = 1'b0;
        #1;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (score !== 16'd0) begin n_bad++; $display("FAIL reset_score: got %0d want 0", score); end
        n_cmp++; if (collide !== 1'b0 || score_inc !== 1'b0) begin n_bad++; $display("FAIL reset_flags: collide=%b inc=%b want 0 0", collide, score_inc); end
        #10 rst_n = 1'b1;
        repeat (20) tick();
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL idle_state: got %0d want 0", state); end
        for (int i = 0; i < 3; i++) begin
            exp_slot = {8'(50*(i+1)), 8'd25, 8'd15};
            n_cmp++; if (pipes[24*i +: 24] !== exp_slot) begin n_bad++; $display("FAIL idle_slot%0d: got %h want %h", i, pipes[24*i +: 24], exp_slot); end
        end
    endtask

    task automatic test_scroll_score();
        int         inc_cnt;
        logic [7:0] l, cand, exp_min;
        bird_alt = 8'd20;
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL run_state: got %0d want 1", state); end
        inc_cnt = 0;
        repeat (150) begin tick(); if (score_inc === 1'b1) inc_cnt++; end
        n_cmp++; if (f_pos(0) !== 8'd0) begin n_bad++; $display("FAIL scroll_pos0: got %0d want 0", f_pos(0)); end
        n_cmp++; if (f_pos(1) !== 8'd50 || f_pos(2) !== 8'd100) begin n_bad++; $display("FAIL scroll_pos12: got %0d %0d want 50 100", f_pos(1), f_pos(2)); end
        n_cmp++; if (score !== 16'd1) begin n_bad++; $display("FAIL scroll_score: got %0d want 1", score); end
        n_cmp++; if (inc_cnt != 1) begin n_bad++; $display("FAIL scroll_inc_pulses: got %0d want 1", inc_cnt); end
        tick(); tick();
        l = m_lfsr;
        cand = 8'd2 + {3'b000, l[4:0]};
        exp_min = ((9'(cand) + 9'd12) > 9'd40) ? 8'd2 : cand;
        tick();
        n_cmp++; if (f_pos(0) !== 8'd150) begin n_bad++; $display("FAIL respawn_pos: got %0d want 150", f_pos(0)); end
        n_cmp++; if (f_min(0) !== exp_min) begin n_bad++; $display("FAIL respawn_min: got %0d want %0d", f_min(0), exp_min); end
        n_cmp++; if (f_max(0) !== exp_min + 8'd10) begin n_bad++; $display("FAIL respawn_max: got %0d want %0d", f_max(0), exp_min + 8'd10); end
        n_cmp++; if (f_pos(1) !== 8'd49) begin n_bad++; $display("FAIL respawn_pos1: got %0d want 49", f_pos(1)); end
        n_cmp++; if (score_inc !== 1'b0 || score !== 16'd1) begin n_bad++; $display("FAIL respawn_score: inc=%b score=%0d want 0 1", score_inc, score); end
    endtask

    task automatic test_collision();
        logic [23:0] exp_slot;
        rst_n = 1'b0; #1 rst_n = 1'b1;
        bird_alt = 8'd30;
        start = 1'b1; tick(); start = 1'b0;
        repeat (144) tick();
        n_cmp++; if (state !== 2'd1 || f_pos(0) !== 8'd2) begin n_bad++; $display("FAIL coll_pre: state=%0d pos0=%0d want 1 2", state, f_pos(0)); end
        tick();
        n_cmp++; if (state !== 2'd2 || collide !== 1'b1) begin n_bad++; $display("FAIL coll_halt: state=%0d collide=%b want 2 1", state, collide); end
        n_cmp++; if (score !== 16'd0) begin n_bad++; $display("FAIL coll_score: got %0d want 0", score); end
        repeat (10) tick();
        n_cmp++; if (f_pos(0) !== 8'd2 || f_pos(1) !== 8'd52 || f_pos(2) !== 8'd102) begin n_bad++; $display("FAIL coll_hold: got %0d %0d %0d want 2 52 102", f_pos(0), f_pos(1), f_pos(2)); end
        n_cmp++; if (state !== 2'd2 || collide !== 1'b1) begin n_bad++; $display("FAIL coll_hold_state: state=%0d collide=%b want 2 1", state, collide); end
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++; if (state !== 2'd0 || collide !== 1'b0 || score !== 16'd0) begin n_bad++; $display("FAIL restart: state=%0d collide=%b score=%0d want 0 0 0", state, collide, score); end
        for (int i = 0; i < 3; i++) begin
            exp_slot = {8'(50*(i+1)), 8'd25, 8'd15};
            n_cmp++; if (pipes[24*i +: 24] !== exp_slot) begin n_bad++; $display("FAIL restart_slot%0d: got %h want %h", i, pipes[24*i +: 24], exp_slot); end
        end
    endtask

    task automatic test_ground_hit();
        bird_alt = 8'd20;
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        bird_alt = 8'd0;
        tick();
        n_cmp++; if (state !== 2'd2 || collide !== 1'b1) begin n_bad++; $display("FAIL ground_halt: state=%0d collide=%b want 2 1", state, collide); end
        n_cmp++; if (f_pos(0) !== 8'd49) begin n_bad++; $display("FAIL ground_pos0: got %0d want 49", f_pos(0)); end
        bird_alt = 8'd20;
        start = 1'b1; tick(); start = 1'b0;
        n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL ground_restart: got %0d want 0", state); end
    endtask

    task automatic test_freeze();
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        n_cmp++; if (f_pos(0) !== 8'd49) begin n_bad++; $display("FAIL frz_pre: got %0d want 49", f_pos(0)); end
        freeze = 1'b1; bird_alt = 8'd0;
        repeat (30) tick();
        n_cmp++; if (state !== 2'd1 || collide !== 1'b0) begin n_bad++; $display("FAIL frz_state: state=%0d collide=%b want 1 0", state, collide); end
        n_cmp++; if (f_pos(0) !== 8'd49 || f_pos(1) !== 8'd99) begin n_bad++; $display("FAIL frz_hold: got %0d %0d want 49 99", f_pos(0), f_pos(1)); end
        freeze = 1'b0; bird_alt = 8'd20;
        tick();
        n_cmp++; if (f_pos(0) !== 8'd49) begin n_bad++; $display("FAIL frz_phase1: got %0d want 49", f_pos(0)); end
        tick();
        n_cmp++; if (f_pos(0) !== 8'd48) begin n_bad++; $display("FAIL frz_phase2: got %0d want 48", f_pos(0)); end
    endtask

    task automatic test_async_reset();
        logic [23:0] exp_slot;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (state !== 2'd0 || score !== 16'd0 || collide !== 1'b0 || score_inc !== 1'b0) begin n_bad++; $display("FAIL areset_outs: state=%0d score=%0d collide=%b inc=%b", state, score, collide, score_inc); end
        for (int i = 0; i < 3; i++) begin
            exp_slot = {8'(50*(i+1)), 8'd25, 8'd15};
            n_cmp++; if (pipes[24*i +: 24] !== exp_slot) begin n_bad++; $display("FAIL areset_slot%0d: got %h want %h", i, pipes[24*i +: 24], exp_slot); end
        end
        n_row = 8'd12;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_small_row();
        bird_alt = 8'd20;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (153) tick();
        n_cmp++; if (f_pos(0) !== 8'd150) begin n_bad++; $display("FAIL small_pos: got %0d want 150", f_pos(0)); end
        n_cmp++; if (f_min(0) !== 8'd2 || f_max(0) !== 8'd12) begin n_bad++; $display("FAIL small_bounds: got %0d %0d want 2 12", f_min(0), f_max(0)); end
        n_cmp++; if (score !== 16'd1) begin n_bad++; $display("FAIL small_score: got %0d want 1", score); end
    endtask

    initial begin
        test_reset();
        test_scroll_score();
        test_collision();
        test_ground_hit();
        test_freeze();
        test_async_reset();
        test_small_row();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
